// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: data accesses win over instruction fetches, but a
// fetch starved for STARVE_MAX consecutive data grants is forced through.
module mem_arbiter #(
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                                clk,
  input  logic                                rst,
  // instruction-fetch port
  input  logic                                if_req,
  input  logic [7:0]                          if_addr,
  output logic                                if_gnt,
  output logic                                if_rvalid,
  output logic [31:0]                         if_rdata,
  // data port
  input  logic                                dm_req,
  input  logic                                dm_we,
  input  logic [7:0]                          dm_addr,
  input  logic [31:0]                         dm_wdata,
  input  logic [2:0]                          dm_func3,
  output logic                                dm_gnt,
  output logic                                dm_rvalid,
  output logic [31:0]                         dm_rdata,
  // memory side
  output logic                                mem_en,
  output logic                                mem_we,
  output logic [7:0]                          mem_addr,
  output logic [31:0]                         mem_wdata,
  output logic [2:0]                          mem_func3,
  input  logic [31:0]                         mem_rdata,
  // pipeline control
  output logic                                stall,
  // debug visibility of internal state
  output logic [1:0]                          dbg_state,
  output logic [$clog2(STARVE_MAX+1)-1:0]     dbg_starve_cnt
);

  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_IF_RD = 2'd1;
  localparam logic [1:0] ST_DM_RD = 2'd2;

  localparam logic [2:0] FETCH_FUNC3 = 3'b010;

  // Handshake: a requester holds req and its payload stable until it sees
  // its gnt high in the same cycle; read data returns exactly one cycle
  // after the grant, flagged by the matching rvalid.

  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic [1:0]    state_q, state_d;
  logic          starved;

  // Grant decision is purely combinational so a lone request never waits.
  always_comb begin
    starved = if_req && (starve_cnt_q == CNT_MAX);
    if_gnt  = if_req && (!dm_req || starved);
    dm_gnt  = dm_req && !starved;
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 32'h0000_0000;
    mem_func3 = 3'b000;
    if (if_gnt) begin
      mem_en    = 1'b1;
      mem_addr  = if_addr;
      mem_func3 = FETCH_FUNC3;
    end else if (dm_gnt) begin
      mem_en    = 1'b1;
      mem_we    = dm_we;
      mem_addr  = dm_addr;
      mem_wdata = dm_wdata;
      mem_func3 = dm_func3;
    end
  end

  // Count consecutive data wins against a waiting fetch; saturates at max.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (if_gnt || !if_req) begin
      starve_cnt_d = '0;
    end else if (dm_gnt && (starve_cnt_q != CNT_MAX)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  // Response tracker: remembers which port owns the read issued last cycle.
  always_comb begin
    state_d = ST_IDLE;
    if (if_gnt) begin
      state_d = ST_IF_RD;
    end else if (dm_gnt && !dm_we) begin
      state_d = ST_DM_RD;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  always_comb begin
    if_rvalid = (state_q == ST_IF_RD);
    dm_rvalid = (state_q == ST_DM_RD);
    if_rdata  = if_rvalid ? mem_rdata : 32'h0000_0000;
    dm_rdata  = dm_rvalid ? mem_rdata : 32'h0000_0000;
    stall     = if_req && !if_gnt;
  end

  assign dbg_state      = state_q;
  assign dbg_starve_cnt = starve_cnt_q;

endmodule
